seq_div_unit: RTL and testbench

- Multi-cycle RV32M divide/remainder unit that responds to divide requests from the execute stage. It replaces the single-cycle combinational divide path.
- Execute stage is the initiator. It issues DIV/DIVU/REM/REMU operands plus a destination tag over a valid/ready request channel.
- The unit returns the 32-bit result and tag over a valid/ready response channel.
- Unit runs a radix-2 restoring divider: one quotient bit per cycle.

---
 rtl/seq_div_unit.sv | 168 ++++++++++++++++
 tb/tb_seq_div_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle RV32M divide/remainder unit.
// A radix-2 restoring divider produces one quotient bit per cycle on
// operand magnitudes; a single FIX cycle applies the signs and selects
// the quotient or the remainder.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_op                    00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_a, req_b, req_tag     dividend, divisor, opaque destination tag
//   flush                     kills any in-flight operation, blocks accept
//   rsp_valid/rsp_ready       response handshake
//   rsp_result, rsp_tag       quotient or remainder, tag of the request
//   busy                      unit is not IDLE
module seq_div_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;    // dividend magnitude, becomes quotient
  logic [XLEN-1:0]   dvs_q, dvs_d;    // divisor magnitude
  logic [XLEN:0]     p_q, p_d;        // partial remainder, one guard bit
  logic [5:0]        cnt_q, cnt_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode
  logic            is_signed, sa, sb, b_zero, ovf, special, accept;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    is_signed = ~req_op[0];
    sa        = is_signed & req_a[XLEN-1];
    sb        = is_signed & req_b[XLEN-1];
    a_mag     = sa ? -req_a : req_a;
    b_mag     = sb ? -req_b : req_b;
    b_zero    = (req_b == '0);
    ovf       = is_signed & (req_a == {1'b1, {(XLEN-1){1'b0}}}) & (req_b == '1);
    special   = b_zero | ovf;
    // Divide by zero returns all ones / the untouched dividend;
    // signed overflow returns the most negative value / zero.
    if (b_zero) special_res = req_op[1] ? req_a : '1;
    else        special_res = req_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    // flush has priority over a same-cycle request
    accept    = req_valid & req_ready & ~flush;
  end

  // Restoring step
  logic [XLEN:0] p_shift, p_diff;
  always_comb begin
    p_shift = {p_q[XLEN-1:0], dvd_q[XLEN-1]};
    p_diff  = p_shift - {1'b0, dvs_q};
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (flush) state_d = IDLE;
            else if (cnt_q == 6'(XLEN-1)) state_d = FIX;
      FIX:  state_d = flush ? IDLE : DONE;
      DONE: if (flush || rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == IDLE);
    rsp_valid  = (state_q == DONE);
    busy       = (state_q != IDLE);
    rsp_result = result_q;
    rsp_tag    = tag_q;
  end

  // Datapath next values
  always_comb begin
    op_d     = op_q;
    tag_d    = tag_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: if (accept) begin
        op_d    = req_op;
        tag_d   = req_tag;
        dvd_d   = a_mag;
        dvs_d   = b_mag;
        p_d     = '0;
        cnt_d   = '0;
        neg_q_d = sa ^ sb;
        neg_r_d = sa;
        if (special) result_d = special_res;
      end
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        if (!p_diff[XLEN]) begin
          p_d   = p_diff;
          dvd_d = {dvd_q[XLEN-2:0], 1'b1};
        end else begin
          p_d   = p_shift;
          dvd_d = {dvd_q[XLEN-2:0], 1'b0};
        end
      end
      FIX: begin
        if (op_q[1]) result_d = neg_r_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
        else         result_d = neg_q_q ? -dvd_q : dvd_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      tag_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      tag_q    <= tag_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_seq_div_unit.sv
module tb_seq_div_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int LAT_NORM = 34;
  localparam int LAT_SPEC = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, flush, rsp_valid, rsp_ready, busy;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_a, req_b, rsp_result;
  logic [TAG_W-1:0] req_tag, rsp_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  typedef struct {
    string            name;
    logic [1:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp;
    int               lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for rsp_valid; lat counts cycles after the accept edge (1 = next cycle).
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    issue(v.op, v.a, v.b, v.tag);
    wait_rsp(lat);
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " result"}, 64'(rsp_result), 64'(v.exp));
    chk({v.name, " tag"}, 64'(rsp_tag), 64'(v.tag));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({v.name, " idle after handshake"}, {62'd0, rsp_valid, req_ready}, 64'b01);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    logic [XLEN-1:0]  hold_res;
    logic [TAG_W-1:0] hold_tag;
    logic             seen;

    vecs.push_back('{"divu 100/7",  2'b01, 32'd100,        32'd7,          5'd17, 32'd14,         LAT_NORM});
    vecs.push_back('{"remu 100/7",  2'b11, 32'd100,        32'd7,          5'd17, 32'd2,          LAT_NORM});
    vecs.push_back('{"div -7/2",    2'b00, 32'hFFFFFFF9,   32'd2,          5'd3,  32'hFFFFFFFD,   LAT_NORM});
    vecs.push_back('{"rem -7/2",    2'b10, 32'hFFFFFFF9,   32'd2,          5'd4,  32'hFFFFFFFF,   LAT_NORM});
    vecs.push_back('{"div 7/-2",    2'b00, 32'd7,          32'hFFFFFFFE,   5'd5,  32'hFFFFFFFD,   LAT_NORM});
    vecs.push_back('{"rem 7/-2",    2'b10, 32'd7,          32'hFFFFFFFE,   5'd6,  32'd1,          LAT_NORM});
    vecs.push_back('{"divu max/1",  2'b01, 32'hFFFFFFFF,   32'd1,          5'd31, 32'hFFFFFFFF,   LAT_NORM});
    vecs.push_back('{"div 42/0",    2'b00, 32'd42,         32'd0,          5'd8,  32'hFFFFFFFF,   LAT_SPEC});
    vecs.push_back('{"remu 42/0",   2'b11, 32'd42,         32'd0,          5'd9,  32'd42,         LAT_SPEC});
    vecs.push_back('{"rem -7/0",    2'b10, 32'hFFFFFFF9,   32'd0,          5'd10, 32'hFFFFFFF9,   LAT_SPEC});
    vecs.push_back('{"div ovf",     2'b00, 32'h80000000,   32'hFFFFFFFF,   5'd11, 32'h80000000,   LAT_SPEC});
    vecs.push_back('{"rem ovf",     2'b10, 32'h80000000,   32'hFFFFFFFF,   5'd12, 32'd0,          LAT_SPEC});
    // unsigned: 2^31 / (2^32-1) is 0 remainder 2^31 on the normal path
    vecs.push_back('{"divu ovf ops", 2'b01, 32'h80000000,  32'hFFFFFFFF,   5'd13, 32'd0,          LAT_NORM});
    vecs.push_back('{"remu ovf ops", 2'b11, 32'h80000000,  32'hFFFFFFFF,   5'd14, 32'h80000000,   LAT_NORM});

    rst = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    flush = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {rsp_valid, req_ready, busy, rsp_result, rsp_tag},
        {1'b0, 1'b1, 1'b0, 32'd0, 5'd0});
    rst = 1'b1;
    @(negedge clk);

    // Async reset in the middle of CALC
    issue(2'b01, 32'd1000, 32'd3, 5'd21);
    repeat (10) @(negedge clk);
    chk("busy before reset", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1 chk("async reset mid-calc", {61'd0, rsp_valid, req_ready, busy}, 64'b010);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_vec('{"divu after reset", 2'b01, 32'd1000, 32'd3, 5'd21, 32'd333, LAT_NORM});

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: hold rsp_ready low for 10 cycles in DONE
    issue(2'b00, 32'hFFFFFF9C, 32'd7, 5'd22);   // -100 / 7 = -14
    wait_rsp(lat);
    chk("bp latency", 64'(lat), 64'(LAT_NORM));
    hold_res = rsp_result;
    hold_tag = rsp_tag;
    chk("bp result", 64'(hold_res), 64'hFFFFFFF2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp stall stable", {rsp_valid, req_ready, rsp_result, rsp_tag},
          {1'b1, 1'b0, 32'hFFFFFFF2, 5'd22});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp release", {62'd0, rsp_valid, req_ready}, 64'b01);

    // Flush at CALC cycle 20: no response ever appears
    issue(2'b01, 32'd500, 32'd5, 5'd23);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush calc -> idle", {61'd0, rsp_valid, req_ready, busy}, 64'b010);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("flush calc no response", 64'(seen), 64'd0);

    // Flush coincident with a request in IDLE blocks the accept
    req_op = 2'b01; req_a = 32'd9; req_b = 32'd3; req_tag = 5'd24;
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("flush blocks accept", {62'd0, busy, req_ready}, 64'b01);
    @(negedge clk);
    chk("flush blocks accept later", {62'd0, busy, rsp_valid}, 64'b00);

    // Flush in DONE drops the pending result
    issue(2'b00, 32'd42, 32'd0, 5'd25);
    chk("done before flush", 64'(rsp_valid), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush done -> idle", {61'd0, rsp_valid, req_ready, busy}, 64'b010);

    // Unit still works after all that
    run_vec('{"div final", 2'b00, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd26, 32'd3, LAT_NORM});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
